// File: rtl/tlb_refill_walker_pkg.sv
// Shared definitions for the TLB refill walker: exception codes, PTE layout and walker states.
package tlb_refill_walker_pkg;

    // Exception codes seen by the pipeline exception logic
    localparam logic [7:0] EXC_UMISS = 8'h82;
    localparam logic [7:0] EXC_KMISS = 8'h83;
    localparam logic [7:0] EXC_UPF   = 8'h84;
    localparam logic [7:0] EXC_KPF   = 8'h85;

    // Page-table entry fields
    localparam int unsigned PTE_V        = 0;
    localparam int unsigned PTE_FRAME_LO = 12;
    localparam int unsigned PTE_FRAME_HI = 17;

    typedef enum logic [2:0] {
        StIdle,
        StL1,
        StL2,
        StFill,
        StFault
    } walk_state_e;

endpackage

// File: rtl/tlb_refill_walker.sv
// Two-level hardware page-table walker that refills the TLB or raises a page fault.
module tlb_refill_walker
    import tlb_refill_walker_pkg::*;
#(
    parameter int unsigned PA_W    = 18,
    parameter int unsigned FRAME_W = 6,
    parameter int unsigned L1_BITS = 10
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            miss_valid,
    output logic            miss_ready,
    input  logic [11:0]     miss_pid,
    input  logic [19:0]     miss_vpn,
    input  logic            miss_kmode,
    input  logic [31:0]     ptbr,
    input  logic            abort,
    output logic            mem_req,
    output logic [PA_W-1:0] mem_addr,
    input  logic            mem_ready,
    input  logic [31:0]     mem_rdata,
    output logic            tlb_we,
    output logic [31:0]     tlb_key,
    output logic [31:0]     tlb_data,
    output logic            done,
    output logic            fault,
    output logic [7:0]      exc
);

    localparam int unsigned L2_BITS = 20 - L1_BITS;

    walk_state_e        state_q, state_d;
    logic [11:0]        pid_q, pid_d;
    logic [19:0]        vpn_q, vpn_d;
    logic               kmode_q, kmode_d;
    logic [FRAME_W-1:0] ptbr_frame_q, ptbr_frame_d;
    logic [FRAME_W-1:0] l2_frame_q, l2_frame_d;
    logic [FRAME_W-1:0] leaf_q, leaf_d;
    logic               abort_pending_q, abort_pending_d;

    logic [FRAME_W-1:0] pte_frame;
    logic [11:0]        l1_offset;
    logic [11:0]        l2_offset;

    assign pte_frame = mem_rdata[PTE_FRAME_LO +: FRAME_W];
    assign l1_offset = 12'({vpn_q[19 -: L1_BITS], 2'b00});
    assign l2_offset = 12'({vpn_q[L2_BITS-1:0], 2'b00});

    // State and capture registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= StIdle;
            pid_q           <= '0;
            vpn_q           <= '0;
            kmode_q         <= 1'b0;
            ptbr_frame_q    <= '0;
            l2_frame_q      <= '0;
            leaf_q          <= '0;
            abort_pending_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            pid_q           <= pid_d;
            vpn_q           <= vpn_d;
            kmode_q         <= kmode_d;
            ptbr_frame_q    <= ptbr_frame_d;
            l2_frame_q      <= l2_frame_d;
            leaf_q          <= leaf_d;
            abort_pending_q <= abort_pending_d;
        end
    end

    // Next-state, capture and output decode
    always_comb begin
        state_d         = state_q;
        pid_d           = pid_q;
        vpn_d           = vpn_q;
        kmode_d         = kmode_q;
        ptbr_frame_d    = ptbr_frame_q;
        l2_frame_d      = l2_frame_q;
        leaf_d          = leaf_q;
        abort_pending_d = abort_pending_q;

        miss_ready = 1'b0;
        mem_req    = 1'b0;
        mem_addr   = '0;
        tlb_we     = 1'b0;
        tlb_key    = '0;
        tlb_data   = '0;
        done       = 1'b0;
        fault      = 1'b0;
        exc        = 8'h00;

        case (state_q)
            StIdle: begin
                miss_ready = 1'b1;
                if (miss_valid) begin
                    pid_d        = miss_pid;
                    vpn_d        = miss_vpn;
                    kmode_d      = miss_kmode;
                    ptbr_frame_d = ptbr[PTE_FRAME_LO +: FRAME_W];
                    state_d      = StL1;
                end
            end
            StL1: begin
                mem_req  = 1'b1;
                mem_addr = PA_W'({ptbr_frame_q, l1_offset});
                if (mem_ready) begin
                    if (abort || abort_pending_q) begin
                        state_d = StIdle;
                    end else if (!mem_rdata[PTE_V]) begin
                        state_d = StFault;
                    end else begin
                        l2_frame_d = pte_frame;
                        state_d    = StL2;
                    end
                end else if (abort) begin
                    // The read is already on the bus; let it finish before dropping the walk.
                    abort_pending_d = 1'b1;
                end
            end
            StL2: begin
                mem_req  = 1'b1;
                mem_addr = PA_W'({l2_frame_q, l2_offset});
                if (mem_ready) begin
                    if (abort || abort_pending_q) begin
                        state_d = StIdle;
                    end else if (!mem_rdata[PTE_V]) begin
                        state_d = StFault;
                    end else begin
                        leaf_d  = pte_frame;
                        state_d = StFill;
                    end
                end else if (abort) begin
                    abort_pending_d = 1'b1;
                end
            end
            StFill: begin
                if (!abort) begin
                    tlb_we   = 1'b1;
                    done     = 1'b1;
                    tlb_key  = {pid_q, vpn_q};
                    tlb_data = 32'(leaf_q);
                end
                state_d = StIdle;
            end
            StFault: begin
                if (!abort) begin
                    fault = 1'b1;
                    exc   = kmode_q ? EXC_KPF : EXC_UPF;
                end
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (state_d == StIdle) begin
            abort_pending_d = 1'b0;
        end
    end

endmodule

// File: tb/tb_tlb_refill_walker.sv
// Scoreboard bench for tlb_refill_walker: directed walks plus randomized walks against a
// page-table reference model; a memory responder serves reads with configurable wait states.
module tb_tlb_refill_walker;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        miss_valid = 1'b0;
    logic        miss_ready;
    logic [11:0] miss_pid = '0;
    logic [19:0] miss_vpn = '0;
    logic        miss_kmode = 1'b0;
    logic [31:0] ptbr = '0;
    logic        abort = 1'b0;
    logic        mem_req;
    logic [17:0] mem_addr;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        tlb_we;
    logic [31:0] tlb_key;
    logic [31:0] tlb_data;
    logic        done;
    logic        fault;
    logic [7:0]  exc;

    tlb_refill_walker #(
        .PA_W    (18),
        .FRAME_W (6),
        .L1_BITS (10)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .miss_valid (miss_valid),
        .miss_ready (miss_ready),
        .miss_pid   (miss_pid),
        .miss_vpn   (miss_vpn),
        .miss_kmode (miss_kmode),
        .ptbr       (ptbr),
        .abort      (abort),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_ready  (mem_ready),
        .mem_rdata  (mem_rdata),
        .tlb_we     (tlb_we),
        .tlb_key    (tlb_key),
        .tlb_data   (tlb_data),
        .done       (done),
        .fault      (fault),
        .exc        (exc)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_fault;
        logic [7:0]  exc;
        logic [31:0] key;
        logic [31:0] data;
        int          lat;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] mem [int];
    int unsigned exp_addr[$];
    int          addr_idx = 0;
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          acc_cyc = 0;
    int          wait_mode = 0;   // fixed wait states per access, or -1 for random

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] rd(int unsigned a);
        return mem.exists(a) ? mem[a] : 32'h0;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference model: walk the table in the memory array using plain address arithmetic.
    task automatic model_walk(input logic [11:0] pid, input logic [19:0] vpn,
                              input logic kmode, input logic [31:0] pt, output exp_t e);
        int unsigned a1, a2;
        logic [31:0] p1, p2;
        int          n;
        exp_addr.delete();
        e.key  = {pid, vpn};
        e.data = 32'h0;
        a1 = int'(pt[17:12]) * 4096 + (int'(vpn) / 1024) * 4;
        exp_addr.push_back(a1);
        p1 = rd(a1);
        n  = 1;
        e.is_fault = 1'b1;
        if (p1[0]) begin
            a2 = int'(p1[17:12]) * 4096 + (int'(vpn) % 1024) * 4;
            exp_addr.push_back(a2);
            p2 = rd(a2);
            n  = 2;
            if (p2[0]) begin
                e.is_fault = 1'b0;
                e.data     = 32'(p2[17:12]);
            end
        end
        e.exc = e.is_fault ? (kmode ? 8'h85 : 8'h84) : 8'h00;
        e.lat = (wait_mode < 0) ? -1 : 1 + n * (wait_mode + 1);
    endtask

    // Memory responder: drives mem_ready/mem_rdata shortly after each rising edge.
    bit busy = 0;
    int wcnt = 0;
    int wtarget = 0;
    always @(posedge clk) begin
        #1;
        if (rst || !mem_req) begin
            mem_ready = 1'b0;
            busy      = 0;
        end else begin
            if (!busy) begin
                busy    = 1;
                wcnt    = 0;
                wtarget = (wait_mode < 0) ? int'($urandom_range(0, 3)) : wait_mode;
            end
            if (wcnt == wtarget) begin
                mem_ready = 1'b1;
                mem_rdata = rd(int'(mem_addr));
                busy      = 0;
            end else begin
                mem_ready = 1'b0;
                mem_rdata = $urandom;
                wcnt++;
            end
        end
    end

    // Monitor: compares DUT outputs with the scoreboard and checks the memory handshake.
    bit          prev_req = 0;
    bit          prev_rdy = 0;
    logic [17:0] prev_addr = '0;
    bit          ready_next = 0;
    always @(negedge clk) begin
        exp_t e;
        bit   rn;
        rn = 0;
        if (rst) begin
            prev_req   = 0;
            ready_next = 0;
        end else begin
            if (ready_next) chk("ready_after_result", 32'(miss_ready), 32'd1);
            if (prev_req && !prev_rdy) begin
                chk("mem_req_held", 32'(mem_req), 32'd1);
                chk("mem_addr_stable", 32'(mem_addr), 32'(prev_addr));
            end
            if (mem_req && mem_ready) begin
                if (addr_idx < exp_addr.size()) begin
                    chk("mem_addr", 32'(mem_addr), exp_addr[addr_idx]);
                end else begin
                    chk("extra_mem_read", 32'(mem_addr), 32'hFFFF_FFFF);
                end
                addr_idx++;
            end
            if (tlb_we || done) begin
                rn = 1;
                chk("done_eq_we", 32'(done), 32'(tlb_we));
                chk("fault_with_done", 32'(fault), 32'd0);
                if (sb.size() == 0) begin
                    chk("unexpected_refill", tlb_key, 32'hFFFF_FFFF);
                end else begin
                    e = sb.pop_front();
                    chk("result_is_fault", 32'(e.is_fault), 32'd0);
                    chk("tlb_key", tlb_key, e.key);
                    chk("tlb_data", tlb_data, e.data);
                    if (e.lat >= 0) chk("fill_latency", cyc - acc_cyc, e.lat);
                end
            end else if (fault) begin
                rn = 1;
                if (sb.size() == 0) begin
                    chk("unexpected_fault", 32'(exc), 32'hFFFF_FFFF);
                end else begin
                    e = sb.pop_front();
                    chk("result_is_fault", 32'(e.is_fault), 32'd1);
                    chk("exc", 32'(exc), 32'(e.exc));
                    if (e.lat >= 0) chk("fault_latency", cyc - acc_cyc, e.lat);
                end
            end else if (exc != 8'h00) begin
                chk("exc_idle", 32'(exc), 32'd0);
            end
            prev_req   = mem_req;
            prev_rdy   = mem_ready;
            prev_addr  = mem_addr;
            ready_next = rn;
        end
    end

    // One miss; kill_kind 0 = abort pulse, 1 = reset pulse, applied kill_at cycles after accept.
    task automatic do_miss(input logic [11:0] pid, input logic [19:0] vpn, input logic kmode,
                           input logic [31:0] pt, input int kill_at, input int kill_kind);
        exp_t e;
        bit   acc;
        bit   idle;
        miss_valid = 1'b1;
        miss_pid   = pid;
        miss_vpn   = vpn;
        miss_kmode = kmode;
        ptbr       = pt;
        acc        = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (miss_ready) begin
                acc = 1;
                break;
            end
            @(posedge clk);
            #1;
        end
        if (!acc) begin
            chk("accept_timeout", 32'd0, 32'd1);
            miss_valid = 1'b0;
            return;
        end
        model_walk(pid, vpn, kmode, pt, e);
        addr_idx = 0;
        acc_cyc  = cyc;
        if (kill_at < 0) sb.push_back(e);
        @(posedge clk);
        #1;
        miss_valid = 1'b0;
        miss_pid   = 12'($urandom);
        miss_vpn   = 20'($urandom);
        miss_kmode = 1'($urandom);
        ptbr       = $urandom;
        idle       = 0;
        for (int k = 1; k < 200; k++) begin
            if (k == kill_at && kill_kind == 0) abort = 1'b1;
            if (k == kill_at && kill_kind == 1) rst = 1'b1;
            @(negedge clk);
            idle = miss_ready;
            if (kill_kind == 1 && k == kill_at + 1) begin
                chk("rst_mem_req", 32'(mem_req), 32'd0);
                chk("rst_miss_ready", 32'(miss_ready), 32'd1);
            end
            @(posedge clk);
            #1;
            abort = 1'b0;
            rst   = 1'b0;
            if (idle) break;
        end
        if (!idle) chk("walk_timeout", 32'd0, 32'd1);
    endtask

    task automatic make_pte(input int unsigned a);
        if (!mem.exists(a)) begin
            mem[a] = ($urandom & 32'hFFFC_0000) | (32'($urandom_range(0, 63)) << 12)
                   | (($urandom & 32'h7FF) << 1) | 32'($urandom_range(0, 9) != 0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] pt;
        logic [19:0] vpn;
        logic [31:0] p1;
        int unsigned a1;
        int          kill;

        mem[32'h23004] = 32'h0000_7001;
        mem[32'h0700C] = 32'h0001_5001;
        mem[32'h23008] = 32'h0000_7000;
        mem[32'h07010] = 32'h0001_5000;

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("reset_miss_ready", 32'(miss_ready), 32'd1);
        chk("reset_mem_req", 32'(mem_req), 32'd0);
        chk("reset_tlb_we", 32'(tlb_we), 32'd0);
        chk("reset_done_fault", 32'({done, fault}), 32'd0);
        chk("reset_exc", 32'(exc), 32'd0);
        chk("reset_key_data", tlb_key | tlb_data, 32'd0);
        @(posedge clk);
        #1;

        // Hit walk, zero-wait, then with three wait states per access
        wait_mode = 0;
        do_miss(12'h005, 20'h00403, 1'b0, 32'h0002_3000, -1, 0);
        wait_mode = 3;
        do_miss(12'h005, 20'h00403, 1'b0, 32'h0002_3000, -1, 0);
        // L1 fault in kernel mode, L2 fault in user mode
        wait_mode = 0;
        do_miss(12'h00A, 20'h00803, 1'b1, 32'h0002_3000, -1, 0);
        do_miss(12'h00B, 20'h00404, 1'b0, 32'h0002_3000, -1, 0);
        // Abort during a pending L2 read, then an immediate new miss
        wait_mode = 3;
        do_miss(12'h005, 20'h00403, 1'b0, 32'h0002_3000, 6, 0);
        wait_mode = 0;
        do_miss(12'h006, 20'h00403, 1'b1, 32'h0002_3000, -1, 0);
        // Reset during L1, then recovery
        wait_mode = 3;
        do_miss(12'h007, 20'h00403, 1'b0, 32'h0002_3000, 1, 1);
        wait_mode = 0;
        do_miss(12'h008, 20'h00403, 1'b0, 32'h0002_3000, -1, 0);

        // Randomized walks with random wait states and occasional aborts
        wait_mode = -1;
        for (int n = 0; n < 150; n++) begin
            pt  = ($urandom & 32'hFFFC_0FFF) | (32'($urandom_range(32, 35)) << 12);
            vpn = 20'($urandom_range(0, 15)) << 10 | 20'($urandom_range(0, 7));
            a1  = int'(pt[17:12]) * 4096 + (int'(vpn) / 1024) * 4;
            make_pte(a1);
            p1 = rd(a1);
            make_pte(int'(p1[17:12]) * 4096 + (int'(vpn) % 1024) * 4);
            kill = ($urandom_range(0, 99) < 15) ? int'($urandom_range(1, 3)) : -1;
            do_miss(12'($urandom), vpn, 1'($urandom), pt, kill, 0);
        end

        repeat (5) @(posedge clk);
        chk("scoreboard_empty", sb.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
